// File: rtl/mux_rr_arb_nb_if.sv
// Handshake bundle for the arbitrating mux: CH producer lanes in, one consumer lane out.
// The mux sits on the slave modport; whoever drives the producers and consumer uses master.
interface mux_rr_arb_nb_if #(
    parameter int n  = 8,
    parameter int CH = 16
);
    logic [CH*n-1:0] D_IN;
    logic [CH-1:0]   VALID_IN;
    logic [CH-1:0]   READY_OUT;
    logic            FORCE_EN;
    logic [3:0]      FORCE_SEL;
    logic [n-1:0]    D_OUT;
    logic            VALID_OUT;
    logic            READY_IN;
    logic [3:0]      SEL_OUT;

    modport slave (
        input  D_IN, VALID_IN, FORCE_EN, FORCE_SEL, READY_IN,
        output READY_OUT, D_OUT, VALID_OUT, SEL_OUT
    );

    modport master (
        output D_IN, VALID_IN, FORCE_EN, FORCE_SEL, READY_IN,
        input  READY_OUT, D_OUT, VALID_OUT, SEL_OUT
    );
endinterface

// File: rtl/mux_rr_arb_nb.sv
// N-channel arbitrating mux with a registered output stage.
// Round-robin or fixed-priority grant, with a manual override; one word per cycle.
module mux_rr_arb_nb #(
    parameter int n    = 8,
    parameter int CH   = 16,
    parameter int MODE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    mux_rr_arb_nb_if.slave    bus
);
    logic [n-1:0] r_dout;
    logic         r_vout;
    logic [3:0]   r_sel;
    logic [3:0]   r_ptr;

    logic [15:0]  w_vld16;
    logic [15:0]  w_oh;
    logic [3:0]   w_gnt;
    logic         w_gnt_vld;
    logic         w_can_load;
    logic         w_xfer;
    logic [n-1:0] w_din;

    // Padding to 16 lanes makes out-of-range FORCE_SEL read as "not valid".
    always_comb begin
        w_vld16         = '0;
        w_vld16[CH-1:0] = bus.VALID_IN;
    end

    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        if (bus.FORCE_EN) begin
            w_gnt     = bus.FORCE_SEL;
            w_gnt_vld = w_vld16[bus.FORCE_SEL];
        end else if (MODE == 1) begin
            for (int i = CH - 1; i >= 0; i--) begin
                if (bus.VALID_IN[i]) begin
                    w_gnt     = 4'(i);
                    w_gnt_vld = 1'b1;
                end
            end
        end else begin
            // Walk backwards so the smallest offset from the pointer wins.
            for (int k = CH - 1; k >= 0; k--) begin
                if (w_vld16[4'((int'(r_ptr) + k) % CH)]) begin
                    w_gnt     = 4'((int'(r_ptr) + k) % CH);
                    w_gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_din = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_gnt == 4'(i)) w_din = bus.D_IN[i*n +: n];
        end
    end

    assign w_can_load    = ~r_vout | bus.READY_IN;
    assign w_xfer        = w_can_load & w_gnt_vld & ~RST;
    assign w_oh          = 16'(1) << w_gnt;
    assign bus.READY_OUT = w_xfer ? w_oh[CH-1:0] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dout <= '0;
            r_vout <= 1'b0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_xfer) begin
            r_dout <= w_din;
            r_sel  <= w_gnt;
            r_vout <= 1'b1;
            if (!bus.FORCE_EN && MODE == 0)
                r_ptr <= (w_gnt == 4'(CH - 1)) ? 4'd0 : w_gnt + 4'd1;
        end else if (r_vout && bus.READY_IN) begin
            r_vout <= 1'b0;
        end
    end

    assign bus.D_OUT     = r_dout;
    assign bus.VALID_OUT = r_vout;
    assign bus.SEL_OUT   = r_sel;
endmodule

// File: tb/tb_mux_rr_arb_nb.sv
// Directed bench for mux_rr_arb_nb: four instances cover RR/16, priority/16, CH=12 and CH=5.
module tb_mux_rr_arb_nb;
    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    mux_rr_arb_nb_if #(.n(8), .CH(16)) if0 ();
    mux_rr_arb_nb_if #(.n(8), .CH(16)) if1 ();
    mux_rr_arb_nb_if #(.n(8), .CH(12)) if2 ();
    mux_rr_arb_nb_if #(.n(8), .CH(5))  if3 ();

    mux_rr_arb_nb #(.n(8), .CH(16), .MODE(0)) u_rr16  (.CLK(CLK), .RST(RST), .bus(if0));
    mux_rr_arb_nb #(.n(8), .CH(16), .MODE(1)) u_pri16 (.CLK(CLK), .RST(RST), .bus(if1));
    mux_rr_arb_nb #(.n(8), .CH(12), .MODE(0)) u_rr12  (.CLK(CLK), .RST(RST), .bus(if2));
    mux_rr_arb_nb #(.n(8), .CH(5),  .MODE(0)) u_rr5   (.CLK(CLK), .RST(RST), .bus(if3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] vld;
        logic        rdy;
        logic        fen;
        logic [3:0]  fsel;
        logic [15:0] ro;
        logic        v;
        logic [7:0]  d;
        logic [3:0]  s;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] oh;
        int          m;

        // priority instance: fixed priority, starvation, backpressure, force
        tbl[0]  = '{16'h0024, 1'b1, 1'b0, 4'd0, 16'h0004, 1'b1, 8'h22, 4'd2};
        tbl[1]  = '{16'h0024, 1'b1, 1'b0, 4'd0, 16'h0004, 1'b1, 8'h22, 4'd2};
        tbl[2]  = '{16'h0020, 1'b1, 1'b0, 4'd0, 16'h0020, 1'b1, 8'h25, 4'd5};
        tbl[3]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 8'h25, 4'd5};
        tbl[4]  = '{16'h0008, 1'b1, 1'b0, 4'd0, 16'h0008, 1'b1, 8'hA5, 4'd3};
        tbl[5]  = '{16'h0010, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 8'hA5, 4'd3};
        tbl[6]  = '{16'h0010, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 8'hA5, 4'd3};
        tbl[7]  = '{16'h0010, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 8'hA5, 4'd3};
        tbl[8]  = '{16'h0010, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 8'hA5, 4'd3};
        tbl[9]  = '{16'h0010, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 8'hA5, 4'd3};
        tbl[10] = '{16'h0010, 1'b1, 1'b0, 4'd0, 16'h0010, 1'b1, 8'h24, 4'd4};
        tbl[11] = '{16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 8'h24, 4'd4};
        tbl[12] = '{16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 8'h24, 4'd4};
        tbl[13] = '{16'h0081, 1'b1, 1'b1, 4'd7, 16'h0080, 1'b1, 8'h27, 4'd7};
        tbl[14] = '{16'h0001, 1'b1, 1'b1, 4'd7, 16'h0000, 1'b0, 8'h27, 4'd7};
        tbl[15] = '{16'hFFFF, 1'b1, 1'b1, 4'd0, 16'h0001, 1'b1, 8'h20, 4'd0};

        for (int i = 0; i < 16; i++) begin
            if0.D_IN[i*8 +: 8] = 8'(8'h10 + i);
            if1.D_IN[i*8 +: 8] = (i == 3) ? 8'hA5 : 8'(8'h20 + i);
        end
        for (int i = 0; i < 12; i++) if2.D_IN[i*8 +: 8] = 8'(8'h30 + i);
        for (int i = 0; i < 5; i++)  if3.D_IN[i*8 +: 8] = 8'(8'h40 + i);

        if0.VALID_IN = 16'hFFFF; if0.READY_IN = 1'b1; if0.FORCE_EN = 1'b0; if0.FORCE_SEL = 4'd0;
        if1.VALID_IN = '0;       if1.READY_IN = 1'b1; if1.FORCE_EN = 1'b0; if1.FORCE_SEL = 4'd0;
        if2.VALID_IN = '0;       if2.READY_IN = 1'b1; if2.FORCE_EN = 1'b0; if2.FORCE_SEL = 4'd0;
        if3.VALID_IN = '0;       if3.READY_IN = 1'b1; if3.FORCE_EN = 1'b0; if3.FORCE_SEL = 4'd0;

        RST = 1'b1;
        edge_wait();
        edge_wait();
        chk("rst_ready_out", 32'(if0.READY_OUT), 32'h0);
        chk("rst_valid_out", 32'(if0.VALID_OUT), 32'h0);
        chk("rst_d_out",     32'(if0.D_OUT),     32'h0);
        chk("rst_sel_out",   32'(if0.SEL_OUT),   32'h0);
        RST = 1'b0;

        // round-robin walk over all 16 channels and back to 0
        for (int k = 0; k < 17; k++) begin
            #1;
            oh = 16'h0001 << (k % 16);
            chk("walk_ready_out", 32'(if0.READY_OUT), 32'(oh));
            edge_wait();
            chk("walk_d_out",   32'(if0.D_OUT),   32'(8'(8'h10 + k % 16)));
            chk("walk_sel_out", 32'(if0.SEL_OUT), 32'(k % 16));
        end

        // forced grant must not move the pointer (now at 1)
        if0.FORCE_EN = 1'b1; if0.FORCE_SEL = 4'd7;
        #1;
        chk("force_ready_out", 32'(if0.READY_OUT), 32'h0080);
        edge_wait();
        chk("force_d_out",   32'(if0.D_OUT),   32'h17);
        chk("force_sel_out", 32'(if0.SEL_OUT), 32'd7);
        if0.VALID_IN = 16'hFF7F;
        #1;
        chk("force_nogrant_ready", 32'(if0.READY_OUT), 32'h0);
        edge_wait();
        chk("force_nogrant_valid", 32'(if0.VALID_OUT), 32'h0);
        chk("force_nogrant_d",     32'(if0.D_OUT),     32'h17);
        if0.FORCE_EN = 1'b0; if0.VALID_IN = 16'hFFFF;
        #1;
        chk("ptr_kept_ready", 32'(if0.READY_OUT), 32'h0002);
        edge_wait();
        chk("ptr_kept_sel", 32'(if0.SEL_OUT), 32'd1);
        chk("ptr_kept_d",   32'(if0.D_OUT),   32'h11);
        if0.VALID_IN = '0;

        for (int i = 0; i < 16; i++) begin
            if1.VALID_IN  = tbl[i].vld;
            if1.READY_IN  = tbl[i].rdy;
            if1.FORCE_EN  = tbl[i].fen;
            if1.FORCE_SEL = tbl[i].fsel;
            #1;
            chk($sformatf("vec%0d_ready_out", i), 32'(if1.READY_OUT), 32'(tbl[i].ro));
            edge_wait();
            chk($sformatf("vec%0d_valid_out", i), 32'(if1.VALID_OUT), 32'(tbl[i].v));
            chk($sformatf("vec%0d_d_out", i),     32'(if1.D_OUT),     32'(tbl[i].d));
            chk($sformatf("vec%0d_sel_out", i),   32'(if1.SEL_OUT),   32'(tbl[i].s));
        end
        if1.VALID_IN = '0;

        // CH=12: out-of-range forced select never grants and the held word drains
        if2.VALID_IN = 12'hFFF;
        #1;
        chk("ch12_load_ready", 32'(if2.READY_OUT), 32'h001);
        edge_wait();
        chk("ch12_load_valid", 32'(if2.VALID_OUT), 32'h1);
        chk("ch12_load_d",     32'(if2.D_OUT),     32'h30);
        if2.FORCE_EN = 1'b1; if2.FORCE_SEL = 4'd13;
        #1;
        chk("ch12_oob_ready", 32'(if2.READY_OUT), 32'h0);
        edge_wait();
        chk("ch12_oob_valid", 32'(if2.VALID_OUT), 32'h0);
        if2.VALID_IN = '0; if2.FORCE_EN = 1'b0;

        // CH=5: wrap from 4 back to 0
        if3.VALID_IN = 5'h1F;
        for (int k = 0; k < 6; k++) begin
            m = k % 5;
            #1;
            oh = 16'h0001 << m;
            chk("ch5_ready_out", 32'(if3.READY_OUT), 32'(oh[4:0]));
            edge_wait();
            chk("ch5_sel_out", 32'(if3.SEL_OUT), 32'(m));
            chk("ch5_d_out",   32'(if3.D_OUT),   32'(8'(8'h40 + m)));
        end

        // reset with a word held: discard it, grant restarts at 0
        RST = 1'b1;
        #1;
        chk("ch5_rst_ready", 32'(if3.READY_OUT), 32'h0);
        edge_wait();
        chk("ch5_rst_valid", 32'(if3.VALID_OUT), 32'h0);
        chk("ch5_rst_d",     32'(if3.D_OUT),     32'h0);
        chk("ch5_rst_sel",   32'(if3.SEL_OUT),   32'h0);
        RST = 1'b0;
        #1;
        chk("ch5_restart_ready", 32'(if3.READY_OUT), 32'h01);
        edge_wait();
        chk("ch5_restart_sel", 32'(if3.SEL_OUT), 32'd0);
        chk("ch5_restart_d",   32'(if3.D_OUT),   32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_arb_nb.md
Name: mux_rr_arb_nb

Overview:
- Parametrised N-channel, n-bit arbitrating multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Generalises the fixed 16:1 combinational select: grant is chosen by round-robin or fixed-priority arbitration, or forced by a manual select.
- Used in the OTTER MCU wherever several producers share one consumer (bus/MMIO return paths, debug taps).

Parameters:
- n, 8, data width of every channel and of D_OUT.
- CH, 16, number of input channels; legal range 2..16.
- MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- D_IN  input  CH*n  flattened channel data; channel i occupies bits [i*n+n-1 : i*n].
- VALID_IN  input  CH  channel i has a word available.
- READY_OUT  output  CH  channel i's word is accepted this cycle (combinational).
- FORCE_EN  input  1  manual mode; arbitration bypassed.
- FORCE_SEL  input  4  channel used when FORCE_EN=1.
- D_OUT  output  n  registered output word.
- VALID_OUT  output  1  D_OUT holds an unconsumed word.
- READY_IN  input  1  consumer accepts D_OUT this cycle.
- SEL_OUT  output  4  index of the channel that supplied D_OUT.

Behaviour:
- Reset (RST=1 at edge): D_OUT=0, VALID_OUT=0, SEL_OUT=0, round-robin pointer=0. READY_OUT=0 during any cycle with RST=1. Reset mid-transfer discards the held word; no handshake completes on that edge.
- Output register state:
  - EMPTY: VALID_OUT=0.
  - FULL: VALID_OUT=1.
- can_load = ~VALID_OUT | READY_IN. An output word drains and a new word loads in the same cycle, giving one word per cycle throughput.
- Grant g (combinational, valid only when can_load=1):
  - FORCE_EN=1: g=FORCE_SEL if FORCE_SEL<CH and VALID_IN[FORCE_SEL]=1, else no grant. FORCE_SEL>=CH never grants, matching the mux default-to-zero case.
  - FORCE_EN=0, MODE=1: lowest i with VALID_IN[i]=1.
  - FORCE_EN=0, MODE=0: first i with VALID_IN[i]=1, searching ptr, ptr+1, …, CH-1, 0, …, ptr-1.
- READY_OUT[g]=1 for the granted channel only. All other bits are 0. READY_OUT never depends on READY_OUT, and is at most one-hot.
- Input transfer (VALID_IN[g] & READY_OUT[g]): at the next edge D_OUT←D_IN slice g, SEL_OUT←g, VALID_OUT←1. Latency: input handshake to VALID_OUT is 1 cycle.
- Output transfer only (VALID_OUT & READY_IN, no grant): VALID_OUT←0. D_OUT and SEL_OUT hold their last values.
- Stall (VALID_OUT & ~READY_IN): D_OUT, SEL_OUT and VALID_OUT are held stable. READY_OUT=0 on all channels.
- Round-robin pointer:
  - Updates only on an input transfer while FORCE_EN=0 and MODE=0: ptr←(g+1) mod CH. Wrap CH-1→0 is required for non-power-of-two CH.
  - Forced transfers and MODE=1 leave ptr unchanged.
- No grant (no valid channel): registers are unchanged except for an output drain.
- Inputs with VALID_IN=0 are never granted, whatever their data.

Test Plan:
- Reset, then CH=16, MODE=0, VALID_IN=16'hFFFF, READY_IN=1, D_IN slice i=i+8'h10 -> D_OUT sequence 10,11,…,1F,10 on consecutive cycles; SEL_OUT 0..15, 0; READY_OUT one-hot walking from bit 0.
- MODE=1, VALID_IN=16'h0024, READY_IN=1 -> channel 2 granted every cycle and channel 5 starved (READY_OUT=0x0004). Dropping VALID_IN[2] -> channel 5 is granted on the next cycle.
- Backpressure: load channel 3 (D=8'hA5), then hold READY_IN=0 for 5 cycles -> D_OUT=A5, SEL_OUT=3, VALID_OUT=1 stable; READY_OUT=0. READY_IN=1 with VALID_IN[4]=1 -> D_OUT takes channel 4 the next cycle with no bubble.
- FORCE_EN=1: FORCE_SEL=7 with VALID_IN[7]=1 -> D_OUT=ch7 data, ptr unchanged. FORCE_SEL=7 with VALID_IN[7]=0 -> no grant. CH=12, FORCE_SEL=13 -> READY_OUT=0 and VALID_OUT drains to 0.
- CH=5, MODE=0, all valid -> grant order 0,1,2,3,4,0 (wrap at 4). RST pulsed while VALID_OUT=1 -> VALID_OUT=0, D_OUT=0 and grant restarts at channel 0.
